// File: rtl/capture_bridge_pkg.sv
// ---------------------------------------------------------------------------
// capture_bridge_pkg
// Shared definitions for the host command bridge of the logic-capture
// configuration register file: FSM state encoding, response bytes, command
// field positions and the default register map geometry, which is also used
// by the capture control register bank.
// ---------------------------------------------------------------------------
package capture_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_DATA = 3'd1,
        ST_WRITE    = 3'd2,
        ST_READ     = 3'd3,
        ST_CAPTURE  = 3'd4,
        ST_RESP     = 3'd5
    } bridge_state_t;

    localparam logic [7:0] ACK_BYTE_DEFAULT   = 8'hAA;
    localparam logic [7:0] NAK_BYTE_DEFAULT   = 8'h55;

    // Command byte: bit 7 selects write (1) or read (0); the low bits carry
    // the register address and everything in between is reserved (must be 0).
    localparam int         CMD_WRITE_BIT      = 7;

    localparam int         REG_COUNT_DEFAULT  = 10;
    localparam int         ADDR_WIDTH_DEFAULT = 4;

    // Mask of the reserved command bits [6:addr_width].
    function automatic logic [7:0] reserved_mask(input int addr_width);
        logic [7:0] m;
        m = 8'h00;
        for (int b = 0; b < CMD_WRITE_BIT; b++) begin
            if (b >= addr_width) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bridge_timeout_counter.sv
// ---------------------------------------------------------------------------
// bridge_timeout_counter
// Counts idle cycles while the bridge waits for the data byte of a write.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   i_clear    in   restart counting from 0
//   i_enable   in   one more idle cycle has elapsed this cycle
//   o_expired  out  this idle cycle is the last one allowed (count at
//                   TIMEOUT_CYCLES-1 while enabled)
// ---------------------------------------------------------------------------
module bridge_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_expired = i_enable && (r_count == LAST);

    // NOTE: state registers use non-blocking assignments and an asynchronous
    // reset branch first, so every flop powers up to a known value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/capture_reg_bridge.sv
// ---------------------------------------------------------------------------
// capture_reg_bridge
// Decodes the host byte stream into register writes/reads on the capture
// control register bank and returns one response byte per command.
// Ports:
//   clk, reset             clock (rising edge), async active-high reset
//   rx_data/valid/ready    command and data bytes from the host receiver
//   tx_data/valid/ready    response byte to the host transmitter
//   reg_addr, reg_wdata    register address and write data (held between
//                          commands)
//   reg_we, reg_re         one-cycle write / read strobes
//   reg_rdata              read data, valid the cycle after reg_re
//   busy                   a command is in progress
// A write returns ACK_BYTE (NAK_BYTE if the command was invalid); a read
// returns the register value (8'h00 if invalid). A write whose data byte
// does not arrive within TIMEOUT_CYCLES idle cycles is silently dropped.
// ---------------------------------------------------------------------------
module capture_reg_bridge
    import capture_bridge_pkg::*;
#(
    parameter int         REG_COUNT      = REG_COUNT_DEFAULT,
    parameter int         ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]            reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [7:0]            reg_rdata,
    output logic                  busy
);

    localparam logic [7:0]          RSVD_MASK = reserved_mask(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REG_COUNT);

    bridge_state_t         r_state;
    bridge_state_t         w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_wdata;
    logic [7:0]            r_tx_data;
    logic                  r_cmd_valid;

    logic                  w_cmd_valid;
    logic                  w_rx_ready;
    logic                  w_tx_valid;
    logic                  w_reg_we;
    logic                  w_reg_re;
    logic                  w_tmo_clear;
    logic                  w_tmo_enable;
    logic                  w_tmo_expired;

    // Validity of the byte on rx_data when interpreted as a command.
    assign w_cmd_valid = ((rx_data & RSVD_MASK) == 8'h00) &&
                         ({1'b0, rx_data[ADDR_WIDTH-1:0]} < REG_LIMIT);

    bridge_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_enable),
        .o_expired (w_tmo_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every signal written here gets its default before the case, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_rx_ready   = 1'b0;
        w_tx_valid   = 1'b0;
        w_reg_we     = 1'b0;
        w_reg_re     = 1'b0;
        w_tmo_clear  = 1'b0;
        w_tmo_enable = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data[CMD_WRITE_BIT]) begin
                        w_next_state = ST_GET_DATA;
                        w_tmo_clear  = 1'b1;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_GET_DATA: begin
                w_rx_ready = 1'b1;
                // A byte arriving in the final allowed cycle still wins.
                if (rx_valid) begin
                    w_next_state = ST_WRITE;
                end else begin
                    w_tmo_enable = 1'b1;
                    if (w_tmo_expired) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                w_reg_we     = r_cmd_valid;
                w_next_state = ST_RESP;
            end
            ST_READ: begin
                w_reg_re     = r_cmd_valid;
                w_next_state = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_tx_valid = 1'b1;
                if (tx_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address/valid flag, write data and response byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_cmd_valid <= 1'b0;
            r_wdata     <= 8'h00;
            r_tx_data   <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        r_addr      <= rx_data[ADDR_WIDTH-1:0];
                        r_cmd_valid <= w_cmd_valid;
                    end
                end
                ST_GET_DATA: begin
                    if (rx_valid) begin
                        r_wdata <= rx_data;
                    end
                end
                ST_WRITE: begin
                    r_tx_data <= r_cmd_valid ? ACK_BYTE : NAK_BYTE;
                end
                ST_CAPTURE: begin
                    r_tx_data <= r_cmd_valid ? reg_rdata : 8'h00;
                end
                default: begin
                end
            endcase
        end
    end

    // rx_ready is decoded from the state, which already sits in IDLE while
    // reset is held; gating with reset keeps it low until reset releases.
    assign rx_ready  = w_rx_ready && !reset;
    assign tx_valid  = w_tx_valid;
    assign tx_data   = r_tx_data;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = w_reg_we;
    assign reg_re    = w_reg_re;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_capture_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_capture_reg_bridge
// Self-checking bench: directed scenarios plus randomized commands, checked
// against a transaction-level model (expected response byte, expected
// register access and its cycle) and a behavioural register bank.
// ---------------------------------------------------------------------------
module tb_capture_reg_bridge;

    localparam int AW   = 4;
    localparam int NREG = 10;
    localparam int TMO  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic          reg_re;
    logic [7:0]    reg_rdata;
    logic          busy;

    always #5 clk = ~clk;

    capture_reg_bridge #(
        .REG_COUNT      (NREG),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO),
        .ACK_BYTE       (8'hAA),
        .NAK_BYTE       (8'h55)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Register bank seen by the DUT: read data appears the cycle after
    // reg_re and is junk otherwise.
    logic [7:0] bank [0:15];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reg_we) bank[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= bank[reg_addr];
        else        reg_rdata <= 8'($urandom);
    end

    // Expected register contents.
    logic [7:0] model_mem [0:15];

    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  a;
        logic [7:0]  d;
    } ev_t;

    ev_t        we_q [$];
    ev_t        re_q [$];
    logic [7:0] tx_q [$];

    // Observed accesses and handshake rules, sampled on the falling edge.
    logic       prev_we   = 1'b0;
    logic       prev_re   = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_txd  = 8'h00;
    int         prot_err  = 0;
    always @(negedge clk) begin
        if (reg_we) we_q.push_back({32'(cyc), 8'(reg_addr), reg_wdata});
        if (reg_re) re_q.push_back({32'(cyc), 8'(reg_addr), reg_wdata});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re) ||
            (tx_valid && rx_ready) ||
            (prev_hold && (!tx_valid || tx_data !== prev_txd)))
            prot_err <= prot_err + 1;
        prev_we   <= reg_we;
        prev_re   <= reg_re;
        prev_hold <= tx_valid && !tx_ready;
        prev_txd  <= tx_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Offers one byte after 'gap' idle cycles; returns the edge it transferred on.
    // Called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, output int edge_n);
        bit ok;
        ok     = 1'b0;
        edge_n = -1;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok     = 1'b1;
                edge_n = cyc + 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        check("rx_accepted", 64'(ok), 64'd1);
    endtask

    function automatic int queued();
        return we_q.size() + re_q.size() + tx_q.size();
    endfunction

    // One complete command: expected results come from the command rules.
    task automatic do_cmd(input logic [7:0] cmd, input logic [7:0] data,
                          input int gap, input int hold);
        bit         is_wr, vld, seen;
        logic [3:0] addr;
        int         nc, nd, first_txv, bad;
        logic [7:0] exp_tx;

        check("idle_quiet", 64'(queued()), 64'd0);
        we_q.delete(); re_q.delete(); tx_q.delete();

        is_wr  = cmd[7];
        addr   = cmd[3:0];
        vld    = (cmd[6:4] == 3'b000) && (int'(addr) < NREG);
        exp_tx = is_wr ? (vld ? 8'hAA : 8'h55) : (vld ? model_mem[addr] : 8'h00);
        nd     = 0;

        tx_ready = (hold == 0);
        send_byte(cmd, 0, nc);
        if (is_wr) send_byte(data, gap, nd);

        seen      = 1'b0;
        first_txv = -1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (tx_valid) begin
                seen      = 1'b1;
                first_txv = cyc;
                break;
            end
        end
        check("tx_valid_seen", 64'(seen), 64'd1);
        check("tx_latency", 64'(first_txv), 64'(is_wr ? nd + 1 : nc + 2));

        if (hold > 0) begin
            bad = 0;
            for (int h = 0; h < hold; h++) begin
                if (!tx_valid || tx_data !== exp_tx || rx_ready || !busy) bad++;
                @(negedge clk);
            end
            check("hold_stable", 64'(bad), 64'd0);
            @(posedge clk);
            #1;
            tx_ready = 1'b1;
        end

        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            if (tx_q.size() > 0) break;
        end
        #1;

        check("tx_count", 64'(tx_q.size()), 64'd1);
        if (tx_q.size() > 0) check("tx_data", 64'(tx_q[0]), 64'(exp_tx));

        check("we_count", 64'(we_q.size()), 64'((is_wr && vld) ? 1 : 0));
        if (is_wr && vld && we_q.size() > 0)
            check("we_event", 64'(we_q[0]), 64'({32'(nd), 8'(addr), data}));

        check("re_count", 64'(re_q.size()), 64'((!is_wr && vld) ? 1 : 0));
        if (!is_wr && vld && re_q.size() > 0)
            check("re_event", 64'({re_q[0].c, re_q[0].a}), 64'({32'(nc), 8'(addr)}));

        check("back_idle", 64'({busy, rx_ready, tx_valid}), 64'(3'b010));

        if (is_wr && vld) model_mem[addr] = data;
        we_q.delete(); re_q.delete(); tx_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nc;
        logic [7:0] cmd;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state",
              64'({rx_ready, tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy}),
              64'd0);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset_ready", 64'({busy, rx_ready, tx_valid}), 64'(3'b010));

        // Basic write to register 2, then fill the whole map.
        do_cmd(8'h82, 8'h3C, 0, 0);
        for (int a = 0; a < NREG; a++) begin
            if (a != 2) do_cmd(8'h80 | 8'(a), 8'($urandom), $urandom_range(0, 3), 0);
        end
        do_cmd(8'h02, 8'h00, 0, 0);

        // Read of register 9 returning 8'h05.
        do_cmd(8'h89, 8'h05, 0, 0);
        do_cmd(8'h09, 8'h00, 0, 0);

        // Invalid commands.
        do_cmd(8'h8C, 8'hFF, 0, 0);
        do_cmd(8'h0F, 8'h00, 0, 0);
        do_cmd(8'hA1, 8'h77, 0, 0);
        do_cmd(8'h01, 8'h00, 0, 0);

        // Backpressure on the response.
        do_cmd(8'h81, 8'h42, 0, 20);

        // Data byte never arrives: the write is dropped silently.
        we_q.delete(); re_q.delete(); tx_q.delete();
        send_byte(8'h83, 0, nc);
        repeat (TMO - 1) @(posedge clk);
        @(negedge clk);
        check("tmo_last_cycle_busy", 64'({busy, rx_ready}), 64'(2'b11));
        @(negedge clk);
        check("tmo_idle", 64'({busy, rx_ready, tx_valid}), 64'(3'b010));
        check("tmo_no_access", 64'(queued()), 64'd0);
        @(posedge clk);
        #1;
        do_cmd(8'h03, 8'h00, 0, 0);

        // Data byte in the final allowed cycle is still accepted.
        do_cmd(8'h84, 8'h5A, TMO - 1, 0);
        do_cmd(8'h04, 8'h00, 0, 0);

        // Reset in the middle of a write frame.
        send_byte(8'h85, 0, nc);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("reset_mid_frame",
              64'({rx_ready, tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy}),
              64'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_no_access", 64'(queued()), 64'd0);
        do_cmd(8'h11, 8'h00, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) < 7)
                cmd = {1'($urandom), 3'b000, 4'($urandom_range(0, 15))};
            else
                cmd = 8'($urandom);
            do_cmd(cmd, 8'($urandom), $urandom_range(0, 6), $urandom_range(0, 3));
        end

        check("protocol_rules", 64'(prot_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/capture_reg_bridge.md
Name: capture_reg_bridge

Overview:
- Host-side command decoder for the logic-capture configuration register file.
- Parses a byte stream from the host serial receiver into register write and read accesses.
- Returns one response byte per command to the host serial transmitter.
- Sits between the UART byte link and the capture control register bank: START, ABORT, channel, edge and pattern configuration, and STATUS.

Parameters:
- REG_COUNT, 10, number of addressable 8-bit registers (valid addresses 0..REG_COUNT-1).
- ADDR_WIDTH, 4, width of the register address field; REG_COUNT <= 2**ADDR_WIDTH.
- TIMEOUT_CYCLES, 1000000, maximum idle clocks allowed between command byte and data byte.
- ACK_BYTE, 8'hAA, response to a successful write.
- NAK_BYTE, 8'h55, response to a rejected write.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from host receiver.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts rx_data this cycle.
- tx_data  out  8  response byte to host transmitter.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts tx_data.
- reg_addr  out  ADDR_WIDTH  register address.
- reg_wdata  out  8  register write data.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read data; valid the cycle after reg_re.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0 (rx_ready, tx_valid, tx_data, reg_addr, reg_wdata, reg_we, reg_re, busy); state IDLE; timeout counter 0.
- Transfers: a byte transfers when valid & ready are both high at a rising edge.
- Command byte format:
  - bit7 = 1 write / 0 read.
  - bits6:ADDR_WIDTH must be 0.
  - bits[ADDR_WIDTH-1:0] = address.
- Command validity: valid iff reserved bits are 0 and address < REG_COUNT.
- States: IDLE, GET_DATA, WRITE, READ, CAPTURE, RESP.
- IDLE:
  - rx_ready = 1.
  - On command transfer, latch address and valid flag.
  - Write command -> GET_DATA, with the timeout counter cleared.
  - Read command -> READ.
- GET_DATA:
  - rx_ready = 1; counter increments each cycle with no transfer.
  - Data transfer -> latch reg_wdata -> WRITE.
  - Counter reaching TIMEOUT_CYCLES-1 with no transfer -> IDLE, no response, no register access.
  - A transfer in that same final cycle wins: accept the byte, no timeout.
- WRITE (1 cycle):
  - reg_we = valid flag.
  - tx_data <= ACK_BYTE if valid, else NAK_BYTE.
  - Next state RESP.
- READ (1 cycle):
  - reg_re = valid flag; reg_addr held.
  - Next state CAPTURE.
- CAPTURE (1 cycle):
  - tx_data <= reg_rdata if valid, else 8'h00.
  - Next state RESP.
- RESP:
  - tx_valid = 1; tx_data stable until transfer.
  - On tx_ready -> IDLE.
  - rx_ready = 0, so no new command is accepted until the response is taken.
- rx_ready is 0 in WRITE, READ, CAPTURE and RESP.
- Latency:
  - Write: data byte accepted at edge N -> reg_we high cycle N+1 -> tx_valid high from cycle N+2.
  - Read: command accepted at edge N -> reg_re high cycle N+1 -> reg_rdata sampled at end of cycle N+2 -> tx_valid high from cycle N+3.
- Strobes: reg_we and reg_re are never both high and never high longer than 1 cycle. Neither is asserted for an invalid command.
- reg_addr and reg_wdata hold their last latched values between commands.
- Reset mid-operation: immediately return to IDLE, all outputs to 0. A partially received frame is discarded and no strobe is emitted.

Decomposition:
- Shared package capture_bridge_pkg:
  - state enum.
  - ACK/NAK byte constants.
  - command bit positions (CMD_WRITE_BIT = 7).
  - default REG_COUNT/ADDR_WIDTH, shared with the capture control register map.
- One sub-module, bridge_timeout_counter: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Write 8'h82 then 8'h3C, tx_ready=1 -> reg_we single pulse with reg_addr=2, reg_wdata=8'h3C; tx_data=8'hAA two cycles after the data byte.
- Read 8'h09 with reg_rdata=8'h05 in the cycle after reg_re -> reg_re single pulse with reg_addr=9; tx_data=8'h05; no reg_we.
- Invalid addresses:
  - Write 8'h8C then 8'hFF -> no reg_we; tx_data=8'h55.
  - Read 8'h0F -> no reg_re; tx_data=8'h00.
  - Command 8'hA1 (reserved bit set) -> treated as invalid (NAK).
- Timeout with TIMEOUT_CYCLES=16: send 8'h83, no further bytes for 16 cycles -> back to IDLE, busy=0, no strobe, no tx_valid. A following 8'h03 read completes normally.
- Backpressure: hold tx_ready=0 for 20 cycles after a write -> tx_valid stays 1 with tx_data=8'hAA stable, rx_ready=0 throughout; release -> one transfer, then IDLE.
- Reset asserted asynchronously while in GET_DATA -> all outputs 0 immediately; after release, data byte 8'h11 is parsed as a new read command to address 1, not as write data.
